// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: state encodings reused by every
// stage that holds entries in a main/skid register pair.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones
// instead of wrapping back to zero.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Advance once per qualifying cycle, holding once the top value is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage. The main register drives the
// output, the skid register catches the one entry that can arrive while
// the downstream stalls. in_ready is registered so there is no
// combinational path from out_ready back to the upstream.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    skid_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_inReady;
    logic             r_outValid;
    logic [1:0]       r_occupancy;

    logic w_accept;
    logic w_pop;
    logic w_stallInc;
    logic w_flushInc;

    assign w_accept   = in_valid & r_inReady;
    assign w_pop      = r_outValid & out_ready;
    assign w_stallInc = r_outValid & ~out_ready;
    assign w_flushInc = flush & (r_occupancy != 2'd0);

    // Occupancy FSM with registered handshake outputs; a flush of an empty
    // stage leaves the held output value untouched and only drops the accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_occupancy <= 2'd0;
        end else if (flush) begin
            if (r_state != EMPTY) begin
                r_state     <= EMPTY;
                r_main      <= '0;
                r_skid      <= '0;
                r_inReady   <= 1'b1;
                r_outValid  <= 1'b0;
                r_occupancy <= 2'd0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data;
                        r_state     <= ONE;
                        r_outValid  <= 1'b1;
                        r_occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid      <= in_data;
                        r_state     <= FULL;
                        r_inReady   <= 1'b0;
                        r_occupancy <= 2'd2;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_outValid  <= 1'b0;
                        r_occupancy <= 2'd0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_main      <= r_skid;
                        r_state     <= ONE;
                        r_inReady   <= 1'b1;
                        r_occupancy <= 2'd1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_main      <= '0;
                    r_skid      <= '0;
                    r_inReady   <= 1'b1;
                    r_outValid  <= 1'b0;
                    r_occupancy <= 2'd0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stallInc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flushInc),
        .count (flush_cnt)
    );

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_main;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue-based model of the two-entry FIFO
// is checked against the DUT on every falling edge, with directed
// scenarios adding literal expectations. A second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic [15:0] inData;
    logic        outReady;

    logic        inReady,  inReady2;
    logic        outValid, outValid2;
    logic [15:0] outData,  outData2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stallCnt, flushCnt;
    logic [1:0]  stallCnt2, flushCnt2;

    int total = 0;
    int bad   = 0;

    logic [15:0] modelQ[$];
    logic [15:0] modelLast = 16'h0000;
    int          modelStall = 0;
    int          modelFlush = 0;

    pipe_skid_stage #(.WIDTH(16), .CNT_W(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .occupancy (occupancy),
        .stall_cnt (stallCnt),
        .flush_cnt (flushCnt)
    );

    pipe_skid_stage #(.WIDTH(16), .CNT_W(2)) u_dutSmall (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady2),
        .in_data   (inData),
        .out_valid (outValid2),
        .out_ready (outReady),
        .out_data  (outData2),
        .occupancy (occupancy2),
        .stall_cnt (stallCnt2),
        .flush_cnt (flushCnt2)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // FIFO model: advance by one clock edge given the inputs present at that edge
    task automatic modelUpdate(input logic v, input logic [15:0] d, input logic r, input logic f);
        int sz;
        sz = modelQ.size();
        if (sz > 0 && !r) modelStall++;
        if (f) begin
            if (sz > 0) begin
                modelFlush++;
                modelQ.delete();
                modelLast = 16'h0000;
            end
        end else begin
            if (sz > 0 && r) modelLast = modelQ.pop_front();
            if (v && sz < 2) modelQ.push_back(d);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelLast  = 16'h0000;
        modelStall = 0;
        modelFlush = 0;
    endtask

    function automatic int satTo3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then settle just after it
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r, input logic f);
        inValid  = v;
        inData   = d;
        outReady = r;
        flush    = f;
        @(posedge clk);
        modelUpdate(v, d, r, f);
        #1;
    endtask

    // Compare both DUT instances against the model on every falling edge
    always @(negedge clk) begin
        logic [15:0] expData;
        int          sz;
        sz      = modelQ.size();
        expData = (sz > 0) ? modelQ[0] : modelLast;
        checkOutput("cyc_in_ready",   32'(inReady),   32'(sz < 2));
        checkOutput("cyc_out_valid",  32'(outValid),  32'(sz > 0));
        checkOutput("cyc_out_data",   32'(outData),   32'(expData));
        checkOutput("cyc_occupancy",  32'(occupancy), 32'(sz));
        checkOutput("cyc_stall_cnt",  32'(stallCnt),  32'(modelStall));
        checkOutput("cyc_flush_cnt",  32'(flushCnt),  32'(modelFlush));
        checkOutput("cyc2_out_valid", 32'(outValid2), 32'(sz > 0));
        checkOutput("cyc2_out_data",  32'(outData2),  32'(expData));
        checkOutput("cyc2_stall_cnt", 32'(stallCnt2), 32'(satTo3(modelStall)));
        checkOutput("cyc2_flush_cnt", 32'(flushCnt2), 32'(satTo3(modelFlush)));
    end

    // Directed scenarios with hand-computed expectations
    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        inData   = 16'h0000;
        outReady = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_in_ready",  32'(inReady),   32'd1);
        checkOutput("rst_out_valid", 32'(outValid),  32'd0);
        checkOutput("rst_out_data",  32'(outData),   32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stallCnt),  32'd0);
        checkOutput("rst_flush_cnt", 32'(flushCnt),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Streaming with no bubbles, latency one
        applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
        checkOutput("stream_v1", 32'(outValid), 32'd1);
        checkOutput("stream_d1", 32'(outData),  32'h0001);
        applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0);
        checkOutput("stream_d2", 32'(outData),  32'h0002);
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
        checkOutput("stream_d3", 32'(outData),  32'h0003);
        checkOutput("stream_rdy", 32'(inReady), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("stream_drain_v", 32'(outValid), 32'd0);
        checkOutput("stream_hold_d",  32'(outData),  32'h0003);

        // Backpressure: fill both registers, third offer ignored
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b0);
        checkOutput("full_occ",   32'(occupancy), 32'd2);
        checkOutput("full_rdy",   32'(inReady),   32'd0);
        checkOutput("full_head",  32'(outData),   32'hAAAA);
        checkOutput("full_stall", 32'(stallCnt),  32'd2);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("pop_first",  32'(outData),   32'hBBBB);
        checkOutput("pop_occ",    32'(occupancy), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("pop_empty",  32'(outValid),  32'd0);
        checkOutput("pop_stall",  32'(stallCnt),  32'd2);

        // Flush while FULL beats a simultaneous offer
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1);
        checkOutput("flush_v",     32'(outValid),  32'd0);
        checkOutput("flush_occ",   32'(occupancy), 32'd0);
        checkOutput("flush_data",  32'(outData),   32'd0);
        checkOutput("flush_cnt",   32'(flushCnt),  32'd1);
        checkOutput("flush_stall", 32'(stallCnt),  32'd4);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("flush_after_v", 32'(outValid), 32'd0);

        // Flush while EMPTY drops the offer and is not counted
        applyStimulus(1'b1, 16'h7777, 1'b1, 1'b1);
        checkOutput("eflush_cnt", 32'(flushCnt),  32'd1);
        checkOutput("eflush_occ", 32'(occupancy), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("eflush_v",   32'(outValid),  32'd0);

        // Asynchronous reset with both registers occupied
        applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0B0B, 1'b0, 1'b0);
        checkOutput("pre_rst_occ", 32'(occupancy), 32'd2);
        #1 reset = 1'b1;
        modelReset();
        #1;
        checkOutput("arst_v",     32'(outValid),  32'd0);
        checkOutput("arst_occ",   32'(occupancy), 32'd0);
        checkOutput("arst_rdy",   32'(inReady),   32'd1);
        checkOutput("arst_data",  32'(outData),   32'd0);
        checkOutput("arst_stall", 32'(stallCnt),  32'd0);
        checkOutput("arst_flush", 32'(flushCnt),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0);
        checkOutput("post_rst_v", 32'(outValid), 32'd1);
        checkOutput("post_rst_d", 32'(outData),  32'h0055);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Saturation of the narrow stall counter
        applyStimulus(1'b1, 16'h0101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("sat_reach", 32'(stallCnt2), 32'd3);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("sat_hold",  32'(stallCnt2), 32'd3);
        checkOutput("sat_wide",  32'(stallCnt),  32'd6);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("sat_pop_d", 32'(outData),   32'h0101);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
